// File: rtl/l_port_arb_ctrl.sv
// rtl/l_port_arb_ctrl.sv - local-port round-robin wormhole arbiter with credit tracking
// Optional error checker enabled by defining L_PORT_ARB_ERR_CHK_EN.
module l_port_arb_ctrl #(
    parameter int         CREDIT_DEPTH = 4,
    parameter int         CREDIT_W     = 3,
    parameter logic [2:0] L_ADDR       = 3'b100
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [2:0]          n_nexthop_addr_i,
    input  logic [2:0]          s_nexthop_addr_i,
    input  logic [2:0]          w_nexthop_addr_i,
    input  logic [2:0]          e_nexthop_addr_i,
    input  logic                n_valid_i,
    input  logic                s_valid_i,
    input  logic                w_valid_i,
    input  logic                e_valid_i,
    input  logic                n_tail_i,
    input  logic                s_tail_i,
    input  logic                w_tail_i,
    input  logic                e_tail_i,
    input  logic                credit_return_i,
    output logic                grant_n_o,
    output logic                grant_s_o,
    output logic                grant_w_o,
    output logic                grant_e_o,
    output logic [2:0]          grant_to_cs_o,
    output logic                flit_fire_o,
    output logic                change_order_o,
`ifdef L_PORT_ARB_ERR_CHK_EN
    output logic                err_o,
`endif
    output logic [CREDIT_W-1:0] credit_count_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_STALL = 2'd2
    } state_t;

    localparam logic [CREDIT_W-1:0] CREDIT_FULL = CREDIT_W'(CREDIT_DEPTH);

    state_t              state, state_nxt;
    logic [1:0]          ptr;
    logic [1:0]          owner;
    logic [CREDIT_W-1:0] credit_count;

    logic [3:0]          valid_v;
    logic [3:0]          tail_v;
    logic [3:0][2:0]     addr_v;
    logic [3:0]          req;
    logic                any_req;
    logic [1:0]          winner;
    logic [1:0]          search_idx;
    logic                owner_valid;
    logic                owner_tail;
    logic                credit_ok;
    logic                fire;
    logic [3:0]          grant_v;

    // Index 0..3 = N, S, W, E throughout.
    assign valid_v = {e_valid_i, w_valid_i, s_valid_i, n_valid_i};
    assign tail_v  = {e_tail_i, w_tail_i, s_tail_i, n_tail_i};
    assign addr_v  = {e_nexthop_addr_i, w_nexthop_addr_i, s_nexthop_addr_i, n_nexthop_addr_i};

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            req[i] = valid_v[i] & (addr_v[i] == L_ADDR);
        end
    end

    assign any_req = |req;

    // Scan from the farthest offset back to ptr so the closest requester wins.
    always_comb begin
        winner     = ptr;
        search_idx = ptr;
        for (int k = 3; k >= 0; k--) begin
            search_idx = ptr + 2'(k);
            if (req[search_idx]) begin
                winner = search_idx;
            end
        end
    end

    assign owner_valid = valid_v[owner];
    assign owner_tail  = tail_v[owner];
    assign credit_ok   = (credit_count != '0);
    assign fire        = (state == S_BUSY) & owner_valid & credit_ok;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (any_req) begin
                    state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                if (fire && owner_tail) begin
                    state_nxt = S_IDLE;
                end else if (fire && (credit_count == CREDIT_W'(1)) && !credit_return_i) begin
                    state_nxt = S_STALL;
                end
            end
            S_STALL: begin
                if (credit_ok) begin
                    state_nxt = S_BUSY;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        grant_v       = 4'b0000;
        grant_to_cs_o = 3'b111;
        if (fire) begin
            grant_v[owner] = 1'b1;
            grant_to_cs_o  = {1'b0, owner};
        end
    end

    assign grant_n_o      = grant_v[0];
    assign grant_s_o      = grant_v[1];
    assign grant_w_o      = grant_v[2];
    assign grant_e_o      = grant_v[3];
    assign flit_fire_o    = fire;
    assign credit_count_o = credit_count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            owner          <= 2'd0;
            ptr            <= 2'd0;
            change_order_o <= 1'b0;
        end else begin
            change_order_o <= fire & owner_tail;
            if ((state == S_IDLE) && any_req) begin
                owner <= winner;
            end
            if (fire && owner_tail) begin
                ptr <= owner + 2'd1;
            end
        end
    end

    // A return at full depth is dropped so the counter never exceeds the buffer size.
    always_ff @(posedge clk) begin
        if (!reset) begin
            credit_count <= CREDIT_FULL;
        end else begin
            case ({credit_return_i, fire})
                2'b10: begin
                    if (credit_count != CREDIT_FULL) begin
                        credit_count <= credit_count + CREDIT_W'(1);
                    end
                end
                2'b01:   credit_count <= credit_count - CREDIT_W'(1);
                default: credit_count <= credit_count;
            endcase
        end
    end

`ifdef L_PORT_ARB_ERR_CHK_EN
    logic [2:0] owner_addr;
    logic [3:0] mid_pkt;
    logic [3:0] owner_onehot;
    logic       err_set;

    always_comb begin
        owner_onehot        = 4'b0000;
        owner_onehot[owner] = 1'b1;
    end

    // A non-owner input that was left mid-packet must not be raising requests with tail set.
    assign err_set = (credit_return_i && (credit_count == CREDIT_FULL))
                   || ((state == S_BUSY) && |(req & ~owner_onehot & tail_v & mid_pkt))
                   || ((state == S_BUSY) && owner_valid && (addr_v[owner] != owner_addr));

    always_ff @(posedge clk) begin
        if (!reset) begin
            owner_addr <= 3'b000;
            mid_pkt    <= 4'b0000;
            err_o      <= 1'b0;
        end else begin
            if ((state == S_IDLE) && any_req) begin
                owner_addr <= addr_v[winner];
            end
            if (fire) begin
                mid_pkt[owner] <= ~owner_tail;
            end
            if (err_set) begin
                err_o <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_l_port_arb_ctrl.sv
// tb/tb_l_port_arb_ctrl.sv - directed and random checks of l_port_arb_ctrl against a behavioural model
module tb_l_port_arb_ctrl;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] addr [4];
    logic       valid [4];
    logic       tail [4];
    logic       ret;

    logic       gn, gs, gw, ge;
    logic [2:0] cs;
    logic       fire_o;
    logic       chg;
    logic [2:0] cred;
`ifdef L_PORT_ARB_ERR_CHK_EN
    logic       err;
`endif

    always #5 clk = ~clk;

    l_port_arb_ctrl #(.CREDIT_DEPTH(DEPTH), .CREDIT_W(3), .L_ADDR(3'b100)) dut (
        .clk              (clk),
        .reset            (reset),
        .n_nexthop_addr_i (addr[0]),
        .s_nexthop_addr_i (addr[1]),
        .w_nexthop_addr_i (addr[2]),
        .e_nexthop_addr_i (addr[3]),
        .n_valid_i        (valid[0]),
        .s_valid_i        (valid[1]),
        .w_valid_i        (valid[2]),
        .e_valid_i        (valid[3]),
        .n_tail_i         (tail[0]),
        .s_tail_i         (tail[1]),
        .w_tail_i         (tail[2]),
        .e_tail_i         (tail[3]),
        .credit_return_i  (ret),
        .grant_n_o        (gn),
        .grant_s_o        (gs),
        .grant_w_o        (gw),
        .grant_e_o        (ge),
        .grant_to_cs_o    (cs),
        .flit_fire_o      (fire_o),
        .change_order_o   (chg),
`ifdef L_PORT_ARB_ERR_CHK_EN
        .err_o            (err),
`endif
        .credit_count_o   (cred)
    );

    int errors = 0;
    int checks = 0;

    // Model: phase 0 = waiting to arbitrate, 1 = packet locked, 2 = waiting for credit
    int m_phase, m_owner, m_ptr, m_cred;
    bit m_chg;

    // Observations from the most recent step, used by the directed scenarios
    logic       s_fire, s_chg;
    logic [2:0] s_cs, s_cred;
    logic [3:0] s_grants;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_owner = 0; m_ptr = 0; m_cred = DEPTH; m_chg = 0;
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < 4; i++) begin
            addr[i] = 3'b000; valid[i] = 1'b0; tail[i] = 1'b0;
        end
        ret = 1'b0;
    endtask

    // Check one cycle against the model, then advance both across the clock edge.
    task automatic step();
        bit         mfire;
        logic [3:0] exp_g;
        int         ncred;
        bit         found;
        #2;
        mfire = (m_phase == 1) && valid[m_owner] && (m_cred > 0);
        exp_g = mfire ? (4'b0001 << m_owner) : 4'b0000;
        s_grants = {ge, gw, gs, gn};
        s_fire = fire_o; s_cs = cs; s_chg = chg; s_cred = cred;
        chk("grants", {4'b0, s_grants}, {4'b0, exp_g});
        chk("cs", {5'b0, cs}, mfire ? 8'(m_owner) : 8'd7);
        chk("fire", {7'b0, fire_o}, {7'b0, mfire});
        chk("chg", {7'b0, chg}, {7'b0, m_chg});
        chk("credit", {5'b0, cred}, 8'(m_cred));
        if (!reset) begin
            model_reset();
        end else begin
            ncred = m_cred + (ret ? 1 : 0) - (mfire ? 1 : 0);
            if (ncred > DEPTH) ncred = DEPTH;
            case (m_phase)
                0: begin
                    found = 0;
                    for (int j = 0; j < 4; j++) begin
                        int p;
                        p = (m_ptr + j) % 4;
                        if (!found && valid[p] && addr[p] == 3'b100) begin
                            found = 1; m_owner = p; m_phase = 1;
                        end
                    end
                end
                1: begin
                    if (mfire && tail[m_owner]) begin
                        m_ptr = (m_owner + 1) % 4; m_phase = 0;
                    end else if (mfire && ncred == 0) begin
                        m_phase = 2;
                    end
                end
                default: begin
                    if (m_cred > 0) m_phase = 1;
                end
            endcase
            m_chg  = mfire && tail[m_owner];
            m_cred = ncred;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    initial begin
        int fires;
        int wgrants;
        int seq [$];

        clear_inputs();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();

        // Reset state
        #1;
        chk("rst_grants", {4'b0, ge, gw, gs, gn}, 8'd0);
        chk("rst_cs", {5'b0, cs}, 8'd7);
        chk("rst_cred", {5'b0, cred}, 8'd4);
        chk("rst_chg", {7'b0, chg}, 8'd0);

        // Basic single-flit grant from N
        valid[0] = 1; addr[0] = 3'b100; tail[0] = 1;
        step();
        chk("basic_idle_nogrant", {7'b0, s_fire}, 8'd0);
        step();
        chk("basic_grant_n", {4'b0, s_grants}, 8'b0001);
        chk("basic_cs", {5'b0, s_cs}, 8'd0);
        valid[0] = 0;
        step();
        chk("basic_chg", {7'b0, s_chg}, 8'd1);
        chk("basic_cred", {5'b0, s_cred}, 8'd3);
        valid[0] = 1; valid[1] = 1; addr[1] = 3'b100; tail[1] = 1;
        step();
        step();
        chk("basic_ptr_s", {5'b0, s_cs}, 8'd1);
        clear_inputs();
        step();

        // Rotation fairness; W targets S so it is never a requester
        do_reset();
        for (int i = 0; i < 4; i++) begin
            valid[i] = 1; tail[i] = 1; addr[i] = (i == 2) ? 3'b001 : 3'b100;
        end
        ret = 1;
        wgrants = 0;
        repeat (8) begin
            step();
            if (s_fire) seq.push_back(int'(s_cs));
            if (s_grants[2]) wgrants++;
        end
        chk("rot_count", 8'(seq.size()), 8'd4);
        if (seq.size() == 4) begin
            chk("rot_0", 8'(seq[0]), 8'd0);
            chk("rot_1", 8'(seq[1]), 8'd1);
            chk("rot_2", 8'(seq[2]), 8'd3);
            chk("rot_3", 8'(seq[3]), 8'd0);
        end
        chk("rot_w_never", 8'(wgrants), 8'd0);

        // Wormhole lock: 3-flit S packet holds off N
        do_reset();
        valid[1] = 1; addr[1] = 3'b100; tail[1] = 0;
        step();
        valid[0] = 1; addr[0] = 3'b100; tail[0] = 1;
        step();
        chk("worm_f1", {5'b0, s_cs}, 8'd1);
        step();
        chk("worm_f2", {5'b0, s_cs}, 8'd1);
        tail[1] = 1;
        step();
        chk("worm_f3", {5'b0, s_cs}, 8'd1);
        valid[1] = 0;
        step();
        chk("worm_idle", {7'b0, s_fire}, 8'd0);
        step();
        chk("worm_n_after", {4'b0, s_grants}, 8'b0001);

        // Credit stall with a 6-flit E packet and no returns
        do_reset();
        valid[3] = 1; addr[3] = 3'b100; tail[3] = 0;
        step();
        fires = 0;
        repeat (4) begin step(); fires += s_fire; end
        chk("stall_four_fires", 8'(fires), 8'd4);
        fires = 0;
        repeat (2) begin step(); fires += s_fire; end
        chk("stall_no_fire", 8'(fires), 8'd0);
        ret = 1;
        step();
        ret = 0;
        fires = s_fire;
        repeat (3) begin step(); fires += s_fire; end
        chk("stall_one_more", 8'(fires), 8'd1);
        chk("stall_cred_zero", {5'b0, s_cred}, 8'd0);

        // Fire and return in the same cycle, then reset mid-packet
        do_reset();
        valid[2] = 1; addr[2] = 3'b100; tail[2] = 0;
        step();
        step();
        step();
        ret = 1;
        step();
        ret = 0;
        step();
        chk("fire_ret_hold", {5'b0, s_cred}, 8'd2);
        valid[0] = 1; addr[0] = 3'b100; tail[0] = 1;
        reset = 0;
        step();
        reset = 1;
        step();
        chk("midrst_cs", {5'b0, s_cs}, 8'd7);
        chk("midrst_cred", {5'b0, s_cred}, 8'd4);
        chk("midrst_fire", {7'b0, s_fire}, 8'd0);
        step();
        chk("midrst_ptr_n", {5'b0, s_cs}, 8'd0);

        // Saturating return at full credit
        do_reset();
        ret = 1;
        step();
        ret = 0;
        step();
        chk("sat_cred", {5'b0, s_cred}, 8'd4);
`ifdef L_PORT_ARB_ERR_CHK_EN
        chk("sat_err", {7'b0, err}, 8'd1);
`endif

        // Randomised traffic against the model
        do_reset();
        repeat (400) begin
            for (int i = 0; i < 4; i++) begin
                valid[i] = ($urandom % 4) != 0;
                addr[i]  = (($urandom % 3) == 0) ? 3'($urandom % 5) : 3'b100;
                tail[i]  = ($urandom % 3) == 0;
            end
            ret   = $urandom % 2;
            reset = ($urandom % 64) != 0;
            step();
        end
        reset = 1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
